// File: rtl/load_bytes_unit.sv
// Load byte/halfword/word unit: issues one aligned memory read, then selects and
// sign/zero-extends the addressed lane before handing it to writeback.
module load_bytes_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_opcode,
  input  logic [31:0] req_addr,
  input  logic [4:0]  req_rd,
  output logic        mem_rd_en,
  output logic [31:0] mem_addr,
  input  logic        mem_rd_valid,
  input  logic [31:0] mem_rd_data,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_data,
  output logic [4:0]  wb_rd,
  output logic        err_valid,
  output logic [1:0]  err_code
);

  localparam logic [5:0] OpLb  = 6'b100000;
  localparam logic [5:0] OpLh  = 6'b100001;
  localparam logic [5:0] OpLw  = 6'b100011;
  localparam logic [5:0] OpLbu = 6'b100100;
  localparam logic [5:0] OpLhu = 6'b100101;

  localparam logic [1:0] ErrMisaligned = 2'b01;
  localparam logic [1:0] ErrIllegal    = 2'b10;
  localparam logic [1:0] ErrTimeout    = 2'b11;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [4:0]  rd_q, rd_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        err_valid_q, err_valid_d;
  logic [1:0]  err_code_q, err_code_d;

  logic        req_legal;
  logic        req_misaligned;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] extracted;

  always_comb begin
    req_legal = (req_opcode == OpLb) || (req_opcode == OpLh) || (req_opcode == OpLw) ||
                (req_opcode == OpLbu) || (req_opcode == OpLhu);
    req_misaligned = 1'b0;
    if ((req_opcode == OpLh) || (req_opcode == OpLhu)) req_misaligned = req_addr[0];
    if (req_opcode == OpLw) req_misaligned = (req_addr[1:0] != 2'b00);
  end

  always_comb begin
    byte_sel = 8'h00;
    unique case (addr_q[1:0])
      2'd0: byte_sel = mem_rd_data[7:0];
      2'd1: byte_sel = mem_rd_data[15:8];
      2'd2: byte_sel = mem_rd_data[23:16];
      2'd3: byte_sel = mem_rd_data[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = addr_q[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];
    unique case (op_q)
      OpLb:    extracted = {{24{byte_sel[7]}}, byte_sel};
      OpLbu:   extracted = {24'h0, byte_sel};
      OpLh:    extracted = {{16{half_sel[15]}}, half_sel};
      OpLhu:   extracted = {16'h0, half_sel};
      default: extracted = mem_rd_data;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    rd_d        = rd_q;
    cnt_d       = cnt_q;
    wb_data_d   = wb_data_q;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          op_d = req_opcode;
          rd_d = req_rd;
          if (!req_legal) begin
            err_valid_d = 1'b1;
            err_code_d  = ErrIllegal;
          end else if (req_misaligned) begin
            err_valid_d = 1'b1;
            err_code_d  = ErrMisaligned;
          end else begin
            // Address only captured for real accesses so mem_addr keeps its last value.
            addr_d  = req_addr;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        cnt_d   = 8'd0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 8'd1;
        if (mem_rd_valid) begin
          wb_data_d = extracted;
          state_d   = StResp;
        end else if (cnt_d == TimeoutCnt) begin
          err_valid_d = 1'b1;
          err_code_d  = ErrTimeout;
          state_d     = StIdle;
        end
      end
      StResp: begin
        if (wb_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      op_q        <= 6'h0;
      addr_q      <= 32'h0;
      rd_q        <= 5'h0;
      cnt_q       <= 8'h0;
      wb_data_q   <= 32'h0;
      err_valid_q <= 1'b0;
      err_code_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      rd_q        <= rd_d;
      cnt_q       <= cnt_d;
      wb_data_q   <= wb_data_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  assign req_ready = (state_q == StIdle);
  assign mem_rd_en = (state_q == StIssue);
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign wb_valid  = (state_q == StResp);
  assign wb_data   = wb_data_q;
  assign wb_rd     = rd_q;
  assign err_valid = err_valid_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_load_bytes_unit.sv
// Directed bench for load_bytes_unit: per-cycle expectations from a lane-extraction
// model, checked on every falling edge, plus literal results for key loads.
module tb_load_bytes_unit;

  localparam int unsigned TO = 16;
  localparam logic [5:0] LB = 6'h20, LH = 6'h21, LW = 6'h23, LBU = 6'h24, LHU = 6'h25;
  localparam logic [5:0] BAD = 6'h28;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [5:0]  req_opcode = 6'h0;
  logic [31:0] req_addr = 32'h0;
  logic [4:0]  req_rd = 5'h0;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic        mem_rd_valid = 1'b0;
  logic [31:0] mem_rd_data = 32'h0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [31:0] wb_data;
  logic [4:0]  wb_rd;
  logic        err_valid;
  logic [1:0]  err_code;

  load_bytes_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_addr(req_addr), .req_rd(req_rd),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_data(wb_data), .wb_rd(wb_rd),
    .err_valid(err_valid), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit run = 1'b0;

  logic        exp_req_ready, exp_mem_rd_en, exp_wb_valid, exp_err_valid;
  logic [1:0]  exp_err_code;
  logic [31:0] exp_mem_addr;
  logic [31:0] exp_wb_data = 32'h0;
  logic [4:0]  exp_wb_rd = 5'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Result of a load, computed arithmetically from the lane rules.
  function automatic logic [31:0] model(input logic [5:0] op, input logic [31:0] addr,
                                        input logic [31:0] word);
    int unsigned b, h;
    b = (word >> (8 * addr[1:0])) & 32'hFF;
    h = (word >> (addr[1] ? 16 : 0)) & 32'hFFFF;
    case (op)
      LB:      return (b >= 128) ? 32'(b) - 32'd256 : 32'(b);
      LBU:     return 32'(b);
      LH:      return (h >= 32768) ? 32'(h) - 32'd65536 : 32'(h);
      LHU:     return 32'(h);
      default: return word;
    endcase
  endfunction

  always @(negedge clk) begin
    if (run && !reset) begin
      chk("req_ready", req_ready, exp_req_ready);
      chk("mem_rd_en", mem_rd_en, exp_mem_rd_en);
      chk("wb_valid", wb_valid, exp_wb_valid);
      chk("err_valid", err_valid, exp_err_valid);
      chk("wb_data", wb_data, exp_wb_data);
      chk("wb_rd", wb_rd, exp_wb_rd);
      if (exp_err_valid) chk("err_code", err_code, exp_err_code);
      if (exp_mem_rd_en) chk("mem_addr", mem_addr, exp_mem_addr);
    end
  end

  // Advance one cycle; inputs and expectations default to an idle cycle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    req_valid     = 1'b0;
    mem_rd_valid  = 1'b0;
    mem_rd_data   = $urandom;
    wb_ready      = 1'b0;
    exp_req_ready = 1'b1;
    exp_mem_rd_en = 1'b0;
    exp_wb_valid  = 1'b0;
    exp_err_valid = 1'b0;
  endtask

  // lat: cycles from strobe to response (>=1); stall: RESP cycles with wb_ready low.
  task automatic load(input logic [5:0] op, input logic [31:0] addr, input logic [4:0] rd,
                      input logic [31:0] word, input int lat, input int stall,
                      input bit use_lit, input logic [31:0] lit);
    next_cycle();
    req_valid = 1'b1; req_opcode = op; req_addr = addr; req_rd = rd;
    next_cycle();
    exp_wb_rd = rd; exp_req_ready = 1'b0;
    exp_mem_rd_en = 1'b1; exp_mem_addr = addr & 32'hFFFF_FFFC;
    for (int i = 1; i < lat; i++) begin
      next_cycle();
      exp_req_ready = 1'b0;
    end
    next_cycle();
    exp_req_ready = 1'b0;
    mem_rd_valid = 1'b1; mem_rd_data = word;
    for (int i = 0; i <= stall; i++) begin
      next_cycle();
      exp_req_ready = 1'b0; exp_wb_valid = 1'b1; exp_wb_data = model(op, addr, word);
      // Stray responses during RESP must not disturb the held result.
      mem_rd_valid = (i % 2 == 0);
      wb_ready = (i == stall);
      if (use_lit && i == 0) begin
        @(negedge clk);
        chk("literal wb_data", wb_data, lit);
      end
    end
  endtask

  task automatic err_req(input logic [5:0] op, input logic [31:0] addr, input logic [4:0] rd,
                         input logic [1:0] code);
    next_cycle();
    req_valid = 1'b1; req_opcode = op; req_addr = addr; req_rd = rd;
    next_cycle();
    exp_wb_rd = rd; exp_err_valid = 1'b1; exp_err_code = code;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("reset req_ready", req_ready, 1);
    chk("reset wb_valid", wb_valid, 0);
    chk("reset err_valid", err_valid, 0);
    chk("reset mem_rd_en", mem_rd_en, 0);
    chk("reset wb_data", wb_data, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    next_cycle();
    run = 1'b1;

    load(LB,  32'h1003, 5'd3,  32'h80FF1234, 1, 0, 1'b1, 32'hFFFFFF80);
    load(LBU, 32'h1002, 5'd4,  32'h80FF1234, 2, 0, 1'b1, 32'h000000FF);
    load(LHU, 32'h1002, 5'd5,  32'h80FF1234, 1, 0, 1'b1, 32'h000080FF);
    load(LH,  32'h1000, 5'd6,  32'h80FF1234, 3, 0, 1'b1, 32'h00001234);
    load(LW,  32'h1000, 5'd7,  32'h80FF1234, 1, 0, 1'b1, 32'h80FF1234);
    load(LH,  32'h2002, 5'd8,  32'h80FF1234, 1, 0, 1'b1, 32'hFFFF80FF);
    load(LB,  32'h2001, 5'd9,  32'h80FF1234, 1, 0, 1'b1, 32'h00000012);

    err_req(LH,  32'h1001, 5'd10, 2'b01);
    err_req(BAD, 32'h1000, 5'd11, 2'b10);
    err_req(LW,  32'h1002, 5'd12, 2'b01);
    err_req(BAD, 32'h1001, 5'd13, 2'b10);
    next_cycle();

    // Timeout: no response for TO wait cycles, then a stray late response.
    next_cycle();
    req_valid = 1'b1; req_opcode = LW; req_addr = 32'h3000; req_rd = 5'd14;
    next_cycle();
    exp_wb_rd = 5'd14; exp_req_ready = 1'b0; exp_mem_rd_en = 1'b1; exp_mem_addr = 32'h3000;
    repeat (TO) begin
      next_cycle();
      exp_req_ready = 1'b0;
    end
    next_cycle();
    exp_err_valid = 1'b1; exp_err_code = 2'b11;
    next_cycle();
    mem_rd_valid = 1'b1; mem_rd_data = 32'hDEADBEEF;
    next_cycle();
    load(LBU, 32'h3001, 5'd15, 32'hA5C3_7E01, 1, 0, 1'b1, 32'h0000007E);

    // Response on the last allowed wait cycle still wins over the timeout.
    load(LHU, 32'h4002, 5'd16, 32'hBEEF_0001, TO, 0, 1'b1, 32'h0000BEEF);

    // Backpressure, then back-to-back loads.
    load(LH,  32'h5000, 5'd17, 32'h1234_8001, 2, 5, 1'b1, 32'hFFFF8001);
    load(LB,  32'h5002, 5'd18, 32'h00F0_0000, 1, 0, 1'b0, 32'h0);
    load(LW,  32'h5004, 5'd19, 32'hCAFE_F00D, 1, 1, 1'b0, 32'h0);
    load(LBU, 32'h5003, 5'd20, 32'h9900_0000, 1, 0, 1'b0, 32'h0);

    // Reset while waiting for memory, then a response after reset.
    next_cycle();
    req_valid = 1'b1; req_opcode = LW; req_addr = 32'h6000; req_rd = 5'd21;
    next_cycle();
    exp_wb_rd = 5'd21; exp_req_ready = 1'b0; exp_mem_rd_en = 1'b1; exp_mem_addr = 32'h6000;
    next_cycle();
    exp_req_ready = 1'b0;
    @(posedge clk);
    #1;
    run = 1'b0;
    reset = 1'b1;
    #2;
    chk("rst req_ready", req_ready, 1);
    chk("rst mem_rd_en", mem_rd_en, 0);
    chk("rst wb_valid", wb_valid, 0);
    chk("rst err_valid", err_valid, 0);
    chk("rst wb_data", wb_data, 0);
    chk("rst wb_rd", wb_rd, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst err_code", err_code, 0);
    exp_wb_data = 32'h0; exp_wb_rd = 5'h0;
    next_cycle();
    reset = 1'b0;
    run = 1'b1;
    mem_rd_valid = 1'b1; mem_rd_data = 32'h1111_2222;
    repeat (3) next_cycle();
    load(LH, 32'h7002, 5'd22, 32'h7FFF_0000, 1, 0, 1'b1, 32'h00007FFF);
    next_cycle();
    next_cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
